// File: rtl/conv_pkg.sv
// Shared types and the output rounding/saturation helper for the 3x3 stride-2 convolution path.
package conv_pkg;
    localparam int DATA_W    = 16;
    localparam int COEF_W    = 16;
    localparam int FRAC_BITS = 8;
    localparam int ACC_W     = 36;
    localparam int K         = 3;
    localparam int TAPS      = K * K;
    localparam int PROD_W    = DATA_W + COEF_W;

    typedef logic signed [DATA_W-1:0] pixel_t;
    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic signed [ACC_W-1:0]  acc_t;
    typedef logic signed [PROD_W-1:0] prod_t;
    typedef pixel_t [TAPS-1:0]        window_t;
    typedef coef_t  [TAPS-1:0]        taps_t;

    localparam acc_t SAT_HI = acc_t'((longint'(1) <<< (DATA_W - 1)) - 1);
    localparam acc_t SAT_LO = acc_t'(-(longint'(1) <<< (DATA_W - 1)));
    localparam acc_t RND    = acc_t'(longint'(1) <<< (FRAC_BITS - 1));

    // Round half up, drop the fraction, clamp to the pixel range, then optional ReLU.
    function automatic pixel_t sat_round_relu(acc_t acc, logic relu);
        acc_t   shifted;
        pixel_t res;
        shifted = (acc + RND) >>> FRAC_BITS;
        if (shifted > SAT_HI)
            res = {1'b0, {(DATA_W-1){1'b1}}};
        else if (shifted < SAT_LO)
            res = {1'b1, {(DATA_W-1){1'b0}}};
        else
            res = shifted[DATA_W-1:0];
        if (relu && res[DATA_W-1])
            res = '0;
        return res;
    endfunction
endpackage

// File: rtl/mac9_tree.sv
// Stages S1-S3 of the convolution MAC: nine products, three row partial sums, bias add.
module mac9_tree
    import conv_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    en,
    input  logic    flush,
    input  logic    vld_in,
    input  window_t win,
    input  taps_t   taps,
    input  pixel_t  bias,
    output logic    vld_out,
    output acc_t    acc
);
    prod_t  [TAPS-1:0] prod_p1;
    pixel_t            bias_p1;
    acc_t   [K-1:0]    psum_p2;
    pixel_t            bias_p2;
    acc_t              acc_p3;
    logic              vld_p1;
    logic              vld_p2;
    logic              vld_p3;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            vld_p3 <= 1'b0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            vld_p3 <= 1'b0;
        end else if (en) begin
            vld_p1 <= vld_in;
            vld_p2 <= vld_p1;
            vld_p3 <= vld_p2;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            // S1: products; bias travels with the window so later coef writes cannot touch it
            for (int k = 0; k < TAPS; k++)
                prod_p1[k] <= prod_t'($signed(win[k]) * $signed(taps[k]));
            bias_p1 <= bias;
            // S2: one partial sum per window row
            for (int r = 0; r < K; r++)
                psum_p2[r] <= acc_t'($signed(prod_p1[K*r])) + acc_t'($signed(prod_p1[K*r+1]))
                            + acc_t'($signed(prod_p1[K*r+2]));
            bias_p2 <= bias_p1;
            // S3: bias is an integer, so align it to the product binary point
            acc_p3 <= psum_p2[0] + psum_p2[1] + psum_p2[2] + (acc_t'($signed(bias_p2)) <<< FRAC_BITS);
        end
    end

    assign vld_out = vld_p3;
    assign acc     = acc_p3;
endmodule

// File: rtl/conv3x3_stride2_mac.sv
// Stride-2 3x3 convolution compute stage: coefficient file, window decimation, MAC pipe, output S4.
module conv3x3_stride2_mac
    import conv_pkg::*;
#(
    parameter int IMG_W   = 8,
    parameter int IMG_H   = 8,
    parameter int STRIDE  = 2,
    parameter bit RELU_EN = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   new_image,
    input  logic                   coef_wr,
    input  logic [3:0]             coef_addr,
    input  logic [COEF_W-1:0]      coef_data,
    input  logic                   win_valid,
    input  logic [TAPS*DATA_W-1:0] win_data,
    output logic                   win_ready,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      out_data,
    output logic [5:0]             out_addr,
    input  logic                   out_ready,
    output logic                   frame_done
);
    localparam int WIN_COLS = IMG_W - 2;
    localparam int WIN_ROWS = IMG_H - 2;
    localparam int OUT_CNT  = ((WIN_COLS + STRIDE - 1) / STRIDE) * ((WIN_ROWS + STRIDE - 1) / STRIDE);
    localparam int COL_W    = $clog2(IMG_W);
    localparam int ROW_W    = $clog2(IMG_H);
    localparam logic [5:0] LAST_ADDR = 6'(OUT_CNT - 1);

    taps_t            taps;
    pixel_t           bias;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             en;
    logic             accept;
    logic             keep;
    logic             out_hs;
    logic             vld_p3;
    acc_t             acc_p3;
    window_t          win;

    assign en         = !out_valid || out_ready;
    assign win_ready  = en && !new_image;
    assign accept     = win_valid && win_ready;
    assign keep       = accept && ((int'(col) % STRIDE) == 0) && ((int'(row) % STRIDE) == 0);
    assign out_hs     = out_valid && out_ready;
    assign frame_done = out_hs && (out_addr == LAST_ADDR);
    assign win        = window_t'(win_data);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            taps <= '0;
            bias <= '0;
        end else if (coef_wr) begin
            for (int k = 0; k < TAPS; k++)
                if (coef_addr == 4'(k))
                    taps[k] <= coef_t'(coef_data);
            if (coef_addr == 4'(TAPS))
                bias <= pixel_t'(coef_data);
        end
    end

    // Every accepted window advances the position, kept or dropped
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col <= '0;
            row <= '0;
        end else if (new_image) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == COL_W'(WIN_COLS - 1)) begin
                col <= '0;
                row <= (row == ROW_W'(WIN_ROWS - 1)) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    mac9_tree u_mac9_tree (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .flush   (new_image),
        .vld_in  (keep),
        .win     (win),
        .taps    (taps),
        .bias    (bias),
        .vld_out (vld_p3),
        .acc     (acc_p3)
    );

    // S4: round, saturate, ReLU into the output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
        end else if (new_image) begin
            out_valid <= 1'b0;
            out_addr  <= '0;
        end else begin
            if (en) begin
                out_valid <= vld_p3;
                if (vld_p3)
                    out_data <= sat_round_relu(acc_p3, RELU_EN);
            end
            if (out_hs)
                out_addr <= (out_addr == LAST_ADDR) ? '0 : out_addr + 6'd1;
        end
    end
endmodule
